// File: rtl/throw_pkg.sv
// Shared types and constants for the projectile-flight stage.
package throw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FLIGHT,
        HOLD
    } state_t;

    localparam int FORCE_MAX = 128;
    localparam int FORCE_W   = 10;
    localparam int X_W       = 11;
    localparam int Y_W       = 11;
    localparam int VX_W      = 5;
    localparam int VY_W      = 8;

    // Saturate the charge-bar force so oversized values behave like a full charge.
    function automatic logic [FORCE_W-1:0] clip_force(input logic [FORCE_W-1:0] raw);
        clip_force = (raw > FORCE_W'(FORCE_MAX)) ? FORCE_W'(FORCE_MAX) : raw;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank flags and 12-bit colour.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport vga_in (
        input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

    modport vga_out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
endinterface

// File: rtl/throw_ball_draw.sv
// Combinational ball overlay; every stream field except rgb passes straight through.
module throw_ball_draw
    import throw_pkg::*;
#(
    parameter int          BALL_SIZE = 8,
    parameter logic [11:0] BALL_RGB  = 12'hFFF
) (
    input  logic        [X_W-1:0] ball_x,
    input  logic signed [Y_W-1:0] ball_y,
    vga_if.vga_in                 vga_in,
    vga_if.vga_out                vga_out
);

    logic        [X_W:0] h_pos;
    logic        [X_W:0] x_lo;
    logic        [X_W:0] x_hi;
    logic signed [Y_W:0] v_pos;
    logic signed [Y_W:0] y_lo;
    logic signed [Y_W:0] y_hi;
    logic                ball_on;

    // Hit test: one extra bit keeps x+BALL_SIZE from wrapping; y is compared signed
    // so a ball above the top edge is clipped instead of wrapping to the bottom.
    always_comb begin
        h_pos   = {1'b0, vga_in.hcount};
        x_lo    = {1'b0, ball_x};
        x_hi    = x_lo + (X_W+1)'(BALL_SIZE);
        v_pos   = $signed({1'b0, vga_in.vcount});
        y_lo    = {ball_y[Y_W-1], ball_y};
        y_hi    = y_lo + (Y_W+1)'(BALL_SIZE);
        ball_on = (h_pos >= x_lo) && (h_pos < x_hi) && (v_pos >= y_lo) && (v_pos < y_hi);
    end

    assign vga_out.vcount = vga_in.vcount;
    assign vga_out.vsync  = vga_in.vsync;
    assign vga_out.vblnk  = vga_in.vblnk;
    assign vga_out.hcount = vga_in.hcount;
    assign vga_out.hsync  = vga_in.hsync;
    assign vga_out.hblnk  = vga_in.hblnk;
    assign vga_out.rgb    = ball_on ? BALL_RGB : vga_in.rgb;

endmodule

// File: rtl/throw_trajectory.sv
// Projectile flight: samples the released throw force, integrates a parabola once
// per frame (vsync rising edge) and overlays the ball on the pixel stream.
module throw_trajectory
    import throw_pkg::*;
#(
    parameter int          X0          = 120,
    parameter int          Y0          = 600,
    parameter int          GROUND_Y    = 700,
    parameter int          X_MAX       = 1023,
    parameter int          BALL_SIZE   = 8,
    parameter int          GRAVITY     = 1,
    parameter int          HOLD_FRAMES = 60,
    parameter logic [11:0] BALL_RGB    = 12'hFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               space,
    input  logic [FORCE_W-1:0] throw_force,
    output logic               in_flight,
    output logic               land_pulse,
    output logic               out_pulse,
    output logic [X_W-1:0]     land_x,
    vga_if.vga_in              vga_in,
    vga_if.vga_out             vga_out
);

    localparam int HC_W = $clog2(HOLD_FRAMES + 1);

    localparam logic        [X_W-1:0]  X0_C     = X_W'(X0);
    localparam logic signed [Y_W-1:0]  Y0_C     = Y_W'(Y0);
    localparam logic signed [Y_W-1:0]  GROUND_C = Y_W'(GROUND_Y);
    localparam logic        [X_W:0]    XMAX_C   = (X_W+1)'(X_MAX);
    localparam logic signed [VY_W-1:0] GRAV_C   = VY_W'(GRAVITY);
    localparam logic        [HC_W-1:0] HOLD_END = HC_W'(HOLD_FRAMES - 1);

    state_t state_reg, state_next;

    logic                   space_reg;
    logic                   vsync_reg;
    logic        [X_W-1:0]  x_reg;
    logic signed [Y_W-1:0]  y_reg;
    logic        [VX_W-1:0] vx_reg;
    logic signed [VY_W-1:0] vy_reg;
    logic        [HC_W-1:0] hold_cnt_reg;
    logic                   land_pulse_reg;
    logic                   out_pulse_reg;
    logic        [X_W-1:0]  land_x_reg;

    logic                   space_fall;
    logic                   frame_tick;
    logic [FORCE_W-1:0]     force_clip;
    logic [VX_W-1:0]        vx_launch;
    logic signed [VY_W-1:0] vy_launch;
    logic        [X_W:0]    x_sum;
    logic signed [Y_W-1:0]  y_diff;
    logic                   x_exit;
    logic                   y_land;
    logic                   hold_done;

    assign space_fall = space_reg & ~space;
    assign frame_tick = vga_in.vsync & ~vsync_reg;

    // Launch velocities: vx = f/8 + 1 (1..17), vy = f/4 (0..32, upward positive).
    assign force_clip = clip_force(throw_force);
    assign vx_launch  = VX_W'((force_clip >> 3) + FORCE_W'(1));
    assign vy_launch  = $signed(VY_W'(force_clip >> 2));

    // Next position from the current velocity; x keeps a carry bit for the edge test.
    assign x_sum     = {1'b0, x_reg} + (X_W+1)'(vx_reg);
    assign y_diff    = y_reg - $signed({{(Y_W-VY_W){vy_reg[VY_W-1]}}, vy_reg});
    assign x_exit    = x_sum > XMAX_C;
    assign y_land    = y_diff >= GROUND_C;
    assign hold_done = (hold_cnt_reg == HOLD_END);

    assign in_flight  = (state_reg == FLIGHT);
    assign land_pulse = land_pulse_reg;
    assign out_pulse  = out_pulse_reg;
    assign land_x     = land_x_reg;

    // Registered copies of space and vsync for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            space_reg <= 1'b0;
            vsync_reg <= 1'b0;
        end else begin
            space_reg <= space;
            vsync_reg <= vga_in.vsync;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; space edges outside IDLE are simply not looked at.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (space_fall) state_next = ARM;
            ARM:     state_next = FLIGHT;
            FLIGHT:  if (frame_tick && (x_exit || y_land)) state_next = HOLD;
            HOLD:    if (frame_tick && hold_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Physics, hold counter and landing/exit strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg          <= X0_C;
            y_reg          <= Y0_C;
            vx_reg         <= '0;
            vy_reg         <= '0;
            hold_cnt_reg   <= '0;
            land_pulse_reg <= 1'b0;
            out_pulse_reg  <= 1'b0;
            land_x_reg     <= '0;
        end else begin
            land_pulse_reg <= 1'b0;
            out_pulse_reg  <= 1'b0;
            case (state_reg)
                ARM: begin
                    vx_reg <= vx_launch;
                    vy_reg <= vy_launch;
                end
                FLIGHT: begin
                    if (frame_tick) begin
                        x_reg        <= x_sum[X_W-1:0];
                        vy_reg       <= vy_reg - GRAV_C;
                        hold_cnt_reg <= '0;
                        // Leaving the screen wins over touching the ground.
                        if (x_exit) begin
                            y_reg         <= y_diff;
                            out_pulse_reg <= 1'b1;
                        end else if (y_land) begin
                            y_reg          <= GROUND_C;
                            land_x_reg     <= x_sum[X_W-1:0];
                            land_pulse_reg <= 1'b1;
                        end else begin
                            y_reg <= y_diff;
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        if (hold_done) begin
                            x_reg        <= X0_C;
                            y_reg        <= Y0_C;
                            vx_reg       <= '0;
                            vy_reg       <= '0;
                            hold_cnt_reg <= '0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + HC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    throw_ball_draw #(
        .BALL_SIZE (BALL_SIZE),
        .BALL_RGB  (BALL_RGB)
    ) u_draw (
        .ball_x  (x_reg),
        .ball_y  (y_reg),
        .vga_in  (vga_in),
        .vga_out (vga_out)
    );

endmodule

// File: tb/tb_throw_trajectory.sv
// Bench for throw_trajectory: table of known throws, random forces against a
// closed-form trajectory model, and hand-written reset / hold / space-edge sequences.
module tb_throw_trajectory;

    localparam int LAND = 1;
    localparam int EXIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        space;
    logic [9:0]  throw_force;
    logic        in_flight;
    logic        land_pulse;
    logic        out_pulse;
    logic [10:0] land_x;

    vga_if vin();
    vga_if vout();

    throw_trajectory dut (
        .clk         (clk),
        .rst         (rst),
        .space       (space),
        .throw_force (throw_force),
        .in_flight   (in_flight),
        .land_pulse  (land_pulse),
        .out_pulse   (out_pulse),
        .land_x      (land_x),
        .vga_in      (vin),
        .vga_out     (vout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int land_cnt = 0;
    int out_cnt  = 0;
    int last_land = 0;

    typedef struct {
        int fval;
        int kind;
        int ticks;
        int ex;
        int ey;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ball position after k frames from the launch, straight from the flight rules.
    function automatic void model_pos(input int fval, input int k, output int px, output int py);
        int f;
        int vx;
        int vy0;
        f   = (fval > 128) ? 128 : fval;
        vx  = f / 8 + 1;
        vy0 = f / 4;
        px  = 120 + vx * k;
        py  = 600 - (vy0 * k - (k * (k - 1)) / 2);
    endfunction

    // Outcome of a throw: first frame leaving the screen or reaching the ground.
    function automatic void model_end(input int fval, output int kind, output int ticks,
                                      output int ex, output int ey);
        int px;
        int py;
        kind = 0; ticks = 0; ex = 0; ey = 0;
        for (int k = 1; k < 1000; k++) begin
            model_pos(fval, k, px, py);
            if (px > 1023) begin
                kind = EXIT; ticks = k; ex = px; ey = py;
                return;
            end else if (py >= 700) begin
                kind = LAND; ticks = k; ex = px; ey = 700;
                return;
            end
        end
    endfunction

    task automatic probe(input int hc, input int vc, output bit on);
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        #1;
        on = (vout.rgb == 12'hFFF);
    endtask

    // Corner probes: inside at both corners, outside just beyond each edge.
    task automatic check_ball(input string name, input int ex, input int ey);
        bit [5:0] pat;
        probe(ex,     ey,     pat[5]);
        probe(ex + 7, ey + 7, pat[4]);
        probe(ex - 1, ey,     pat[3]);
        probe(ex,     ey - 1, pat[2]);
        probe(ex + 8, ey + 7, pat[1]);
        probe(ex + 7, ey + 8, pat[0]);
        chk($sformatf("%s(%0d,%0d)", name, ex, ey), int'(pat), 6'b110000);
    endtask

    task automatic sample_pulses();
        if (land_pulse) land_cnt++;
        if (out_pulse)  out_cnt++;
    endtask

    // One frame: a single vsync rising edge, pulses sampled every cycle around it.
    task automatic tick();
        @(negedge clk) vin.vsync = 1'b1;
        @(negedge clk) sample_pulses();
        @(negedge clk) sample_pulses();
        vin.vsync = 1'b0;
        @(negedge clk) sample_pulses();
        @(negedge clk) sample_pulses();
    endtask

    // Press/release space; force changed so a wrong relaunch would alter the flight.
    task automatic space_poke();
        @(negedge clk) space = 1'b1;
        @(negedge clk) space = 1'b0;
        throw_force = 10'd0;
        @(negedge clk);
    endtask

    // Release space with the force arriving one cycle after the edge.
    task automatic launch(input int fval);
        @(negedge clk) space = 1'b1;
        repeat (2) @(negedge clk);
        space = 1'b0;
        throw_force = (fval >= 64) ? 10'd0 : 10'd128;
        @(negedge clk);
        throw_force = 10'(fval);
        chk("arm_in_flight", int'(in_flight), 0);
        @(negedge clk);
        chk("launch_in_flight", int'(in_flight), 1);
    endtask

    task automatic fly(input int fval, input bit poke, output int kind, output int ticks);
        int px;
        int py;
        land_cnt = 0;
        out_cnt  = 0;
        ticks    = 0;
        for (int k = 1; k <= 120; k++) begin
            if (poke && (k % 7 == 3)) space_poke();
            tick();
            if (!in_flight) begin
                ticks = k;
                break;
            end
            model_pos(fval, k, px, py);
            check_ball("flight_pos", px, py);
        end
        if (ticks == 0) chk("flight_timeout", 0, 1);
        if (land_cnt == 1 && out_cnt == 0)      kind = LAND;
        else if (out_cnt == 1 && land_cnt == 0) kind = EXIT;
        else                                    kind = -(land_cnt * 10 + out_cnt);
    endtask

    task automatic hold_phase(input int ex, input int ey, input bit space_last);
        for (int k = 1; k <= 59; k++) begin
            if (k == 30) space_poke();
            tick();
        end
        chk("hold_in_flight", int'(in_flight), 0);
        check_ball("hold_frozen", ex, ey);
        if (space_last) begin
            @(negedge clk) space = 1'b1;
            @(negedge clk);
        end
        @(negedge clk) begin
            vin.vsync = 1'b1;
            if (space_last) space = 1'b0;
        end
        repeat (2) @(negedge clk);
        vin.vsync = 1'b0;
        repeat (2) @(negedge clk);
        check_ball("idle_home", 120, 600);
        chk("idle_in_flight", int'(in_flight), 0);
        if (space_last) begin
            tick();
            check_ball("no_relaunch", 120, 600);
            chk("no_relaunch_in_flight", int'(in_flight), 0);
        end
    endtask

    task automatic do_throw(input string tag, input int fval, input int kind_e, input int ticks_e,
                            input int ex_e, input int ey_e, input bit poke, input bit space_last);
        int kind;
        int ticks;
        launch(fval);
        fly(fval, poke, kind, ticks);
        chk({tag, "_kind"}, kind, kind_e);
        chk({tag, "_ticks"}, ticks, ticks_e);
        check_ball({tag, "_end_pos"}, ex_e, ey_e);
        if (kind_e == LAND) last_land = ex_e;
        chk({tag, "_land_x"}, int'(land_x), last_land);
        $display("throw %s force=%0d kind=%0d ticks=%0d land_x=%0d", tag, fval, kind, ticks, land_x);
        hold_phase(ex_e, ey_e, space_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        int ticks;
        int ex;
        int ey;
        int fval;

        vecs[0] = '{0,   LAND, 15, 135,  700};
        vecs[1] = '{40,  LAND, 29, 294,  700};
        vecs[2] = '{128, EXIT, 54, 1038, 303};
        vecs[3] = '{300, EXIT, 54, 1038, 303};

        rst = 1'b1;
        space = 1'b0;
        throw_force = 10'd0;
        vin.hcount = 11'd0;
        vin.vcount = 11'd0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = 12'h0A5;
        repeat (3) @(negedge clk);

        chk("reset_in_flight", int'(in_flight), 0);
        chk("reset_land_pulse", int'(land_pulse), 0);
        chk("reset_out_pulse", int'(out_pulse), 0);
        chk("reset_land_x", int'(land_x), 0);
        check_ball("reset_home", 120, 600);
        rst = 1'b0;
        @(negedge clk);

        vin.hsync = 1'b1;
        vin.vblnk = 1'b1;
        vin.hcount = 11'd5;
        vin.vcount = 11'd9;
        #1;
        chk("pass_hsync", int'(vout.hsync), 1);
        chk("pass_vblnk", int'(vout.vblnk), 1);
        chk("pass_hcount", int'(vout.hcount), 5);
        chk("pass_vcount", int'(vout.vcount), 9);
        chk("pass_rgb", int'(vout.rgb), 12'h0A5);
        vin.hsync = 1'b0;
        vin.vblnk = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_throw($sformatf("table%0d", i), vecs[i].fval, vecs[i].kind, vecs[i].ticks,
                     vecs[i].ex, vecs[i].ey, (i == 3), (i == 0));
        end

        for (int r = 0; r < 5; r++) begin
            fval = int'($urandom_range(0, 1023));
            model_end(fval, kind, ticks, ex, ey);
            do_throw($sformatf("rand%0d", r), fval, kind, ticks, ex, ey, 1'b0, 1'b0);
        end

        launch(40);
        for (int k = 1; k <= 10; k++) tick();
        chk("pre_reset_in_flight", int'(in_flight), 1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("midrst_in_flight", int'(in_flight), 0);
        chk("midrst_land_pulse", int'(land_pulse), 0);
        chk("midrst_out_pulse", int'(out_pulse), 0);
        chk("midrst_land_x", int'(land_x), 0);
        check_ball("midrst_home", 120, 600);
        $display("reset asserted mid-flight after 10 frames");
        @(negedge clk) rst = 1'b0;
        last_land = 0;
        do_throw("after_reset", 40, LAND, 29, 294, 700, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
